// File: rtl/rbe_input_pingpong_register.sv
// rbe_input_pingpong_register
//   Double-buffered feature register. Two banks hold up to NREG TP-bit words each.
//   One bank fills from the TCDM-side stream while the other is replayed o_rep times
//   to the binary-conv engine, so load and extract overlap without a bubble.
//
// Parameters
//   TP       word width (input elements per beat)
//   NREG     max words per vector per bank (>= 2)
//   CNT_SIZE width of the repetition count
//   VW       width of i_vlen_i, derived as $clog2(NREG)+1
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   enable_i          0 freezes all state and drops ready/valid
//   clear_i           synchronous flush, same effect as rst_i
//   i_vlen_i, o_rep_i words per vector / replays, latched at each bank's first beat
//   feat_i_*          sink stream (strb ignored)
//   feat_o_*          source stream (strb tied high), data is 0 when not valid
//   last_o            last word of the last replay of a bank
//   bank_full_o       per-bank full flags
//   busy_o            any bank full or a load partially done
//   err_o             only with RBE_INPUT_PINGPONG_ERR_EN: sticky flag for out-of-range
//                     vlen/rep seen at a first-beat latch
module rbe_input_pingpong_register #(
  parameter  int TP       = 32,
  parameter  int NREG     = 9,
  parameter  int CNT_SIZE = 8,
  localparam int VW       = $clog2(NREG) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [VW-1:0]       i_vlen_i,
  input  logic [CNT_SIZE-1:0] o_rep_i,
  input  logic [TP-1:0]       feat_i_data,
  input  logic                feat_i_valid,
  output logic                feat_i_ready,
  input  logic [(TP+7)/8-1:0] feat_i_strb,
  output logic [TP-1:0]       feat_o_data,
  output logic                feat_o_valid,
  input  logic                feat_o_ready,
  output logic [(TP+7)/8-1:0] feat_o_strb,
  output logic                last_o,
  output logic [1:0]          bank_full_o,
  output logic                busy_o
`ifdef RBE_INPUT_PINGPONG_ERR_EN
  ,
  output logic                err_o
`endif
);

  localparam int IW = $clog2(NREG);

  logic [1:0]               full_q, full_d;
  logic                     wr_sel_q, rd_sel_q;
  logic [VW-1:0]            wr_cnt_q, rd_idx_q;
  logic [CNT_SIZE-1:0]      rep_cnt_q;
  logic [1:0][VW-1:0]       vlen_q;
  logic [1:0][CNT_SIZE-1:0] rep_q;
  logic [TP-1:0]            bank_q [2][NREG];

  logic [VW-1:0]       eff_vlen, cur_vlen, rd_vlen;
  logic [CNT_SIZE-1:0] eff_rep, rd_rep;
  logic flush, first_beat, wr_hs, wr_done, rd_hs, rd_wrap, rd_rel;

  logic unused_strb;
  assign unused_strb = ^feat_i_strb;
  assign feat_o_strb = '1;

  always_comb begin
    eff_vlen = i_vlen_i;
    if (i_vlen_i == '0)              eff_vlen = VW'(1);
    else if (i_vlen_i > VW'(NREG))   eff_vlen = VW'(NREG);
    eff_rep = (o_rep_i == '0) ? CNT_SIZE'(1) : o_rep_i;
  end

  assign flush      = rst_i | clear_i;
  assign first_beat = (wr_cnt_q == '0);
  // The first beat completes against the live (clamped) length, later beats against the latched one.
  assign cur_vlen   = first_beat ? eff_vlen : vlen_q[wr_sel_q];

  // Write side
  assign feat_i_ready = enable_i & ~flush & ~full_q[wr_sel_q];
  assign wr_hs        = feat_i_valid & feat_i_ready;
  assign wr_done      = wr_hs & (wr_cnt_q == cur_vlen - VW'(1));

  // Read side
  assign rd_vlen      = vlen_q[rd_sel_q];
  assign rd_rep       = rep_q[rd_sel_q];
  assign feat_o_valid = enable_i & full_q[rd_sel_q];
  assign rd_wrap      = (rd_idx_q == rd_vlen - VW'(1));
  assign last_o       = feat_o_valid & rd_wrap & (rep_cnt_q == rd_rep - CNT_SIZE'(1));
  assign rd_hs        = feat_o_valid & feat_o_ready;
  assign rd_rel       = rd_hs & last_o;
  assign feat_o_data  = feat_o_valid ? bank_q[rd_sel_q][rd_idx_q[IW-1:0]] : '0;

  assign bank_full_o = full_q;
  assign busy_o      = (|full_q) | (wr_cnt_q != '0);

  // Write-complete and release always target different banks (full gates each side),
  // so setting and clearing in the same cycle never collide.
  always_comb begin
    full_d = full_q;
    if (wr_done) full_d[wr_sel_q] = 1'b1;
    if (rd_rel)  full_d[rd_sel_q] = 1'b0;
  end

  // Storage carries no reset: contents are meaningless until a bank is refilled.
  always_ff @(posedge clk_i) begin
    if (wr_hs) bank_q[wr_sel_q][wr_cnt_q[IW-1:0]] <= feat_i_data;
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      full_q    <= '0;
      wr_sel_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      wr_cnt_q  <= '0;
      rd_idx_q  <= '0;
      rep_cnt_q <= '0;
      vlen_q    <= '0;
      rep_q     <= '0;
    end else begin
      if (wr_hs) begin
        if (first_beat) begin
          vlen_q[wr_sel_q] <= eff_vlen;
          rep_q[wr_sel_q]  <= eff_rep;
        end
        if (wr_done) begin
          wr_cnt_q <= '0;
          wr_sel_q <= ~wr_sel_q;
        end else begin
          wr_cnt_q <= wr_cnt_q + VW'(1);
        end
      end
      if (rd_hs) begin
        if (rd_wrap) begin
          rd_idx_q <= '0;
          if (last_o) begin
            rep_cnt_q <= '0;
            rd_sel_q  <= ~rd_sel_q;
          end else begin
            rep_cnt_q <= rep_cnt_q + CNT_SIZE'(1);
          end
        end else begin
          rd_idx_q <= rd_idx_q + VW'(1);
        end
      end
      full_q <= full_d;
    end
  end

`ifdef RBE_INPUT_PINGPONG_ERR_EN
  logic err_q;
  always_ff @(posedge clk_i) begin
    if (flush) err_q <= 1'b0;
    else if (wr_hs && first_beat &&
             (i_vlen_i == '0 || i_vlen_i > VW'(NREG) || o_rep_i == '0))
      err_q <= 1'b1;
  end
  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_rbe_input_pingpong_register.sv
module tb_rbe_input_pingpong_register;
  localparam int TP = 16, NREG = 9, CNT_SIZE = 4, VW = $clog2(NREG) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, clr;
  logic [VW-1:0]       vlen_in;
  logic [CNT_SIZE-1:0] rep_in;
  logic [TP-1:0]       feat_i_data, feat_o_data;
  logic                feat_i_valid, feat_i_ready, feat_o_valid, feat_o_ready;
  logic [TP/8-1:0]     feat_i_strb, feat_o_strb;
  logic                last_o, busy_o;
  logic [1:0]          bank_full_o;
`ifdef RBE_INPUT_PINGPONG_ERR_EN
  logic err_o;
`endif

  rbe_input_pingpong_register #(.TP(TP), .NREG(NREG), .CNT_SIZE(CNT_SIZE)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
    .i_vlen_i(vlen_in), .o_rep_i(rep_in),
    .feat_i_data(feat_i_data), .feat_i_valid(feat_i_valid), .feat_i_ready(feat_i_ready),
    .feat_i_strb(feat_i_strb),
    .feat_o_data(feat_o_data), .feat_o_valid(feat_o_valid), .feat_o_ready(feat_o_ready),
    .feat_o_strb(feat_o_strb),
    .last_o(last_o), .bank_full_o(bank_full_o), .busy_o(busy_o)
`ifdef RBE_INPUT_PINGPONG_ERR_EN
    , .err_o(err_o)
`endif
  );

  // Reference model: vectors as whole units. A completed vector expands into its
  // replay stream (words x rep) appended to an expected-beat queue.
  typedef struct { logic [TP-1:0] d; logic l; } beat_t;
  beat_t         exp_q[$];
  logic [TP-1:0] part_q[$];
  int pv, pr, occ, n_done, n_rel;
  bit err_m;
  int n_chk = 0, n_err = 0;
  int obs_beats = 0, obs_last = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    exp_q.delete(); part_q.delete();
    occ = 0; n_done = 0; n_rel = 0; err_m = 0;
  endtask

  // Pending vectors alternate banks starting from bank 0 after a flush.
  function automatic logic [1:0] bf_exp();
    logic [1:0] r = 2'b00;
    for (int i = n_rel; i < n_done; i++) r[i % 2] = 1'b1;
    return r;
  endfunction

  // One clock cycle: drive, check against the model, clock, update the model.
  task automatic cyc(input logic iv, input logic [TP-1:0] id, input logic ordy, output bit whs);
    logic rdy_m, vld_m, rhs;
    int v_s, r_s;
    beat_t e;
    feat_i_valid = iv; feat_i_data = id; feat_o_ready = ordy;
    #2;
    rdy_m = en && !clr && !rst && occ < 2;
    vld_m = en && occ > 0;
    chk("ready", feat_i_ready, rdy_m);
    chk("valid", feat_o_valid, vld_m);
    chk("bank_full", bank_full_o, bf_exp());
    chk("busy", busy_o, (occ > 0 || part_q.size() > 0));
    if (vld_m) begin
      chk("data", feat_o_data, exp_q[0].d);
      chk("last", last_o, exp_q[0].l);
    end else begin
      chk("data_idle", feat_o_data, 0);
      chk("last_idle", last_o, 0);
    end
`ifdef RBE_INPUT_PINGPONG_ERR_EN
    chk("err", err_o, err_m);
`endif
    if (feat_o_valid && ordy) obs_beats++;
    if (feat_o_valid && ordy && last_o) obs_last++;
    whs = rdy_m && iv;
    rhs = vld_m && ordy;
    v_s = int'(vlen_in); r_s = int'(rep_in);
    @(posedge clk); #1;
    if (rst || clr) model_flush();
    else begin
      if (rhs) begin
        e = exp_q.pop_front();
        if (e.l) begin occ--; n_rel++; end
      end
      if (whs) begin
        if (part_q.size() == 0) begin
          pv = (v_s == 0) ? 1 : (v_s > NREG ? NREG : v_s);
          pr = (r_s == 0) ? 1 : r_s;
          if (v_s == 0 || v_s > NREG || r_s == 0) err_m = 1;
        end
        part_q.push_back(id);
        if (part_q.size() == pv) begin
          for (int r = 0; r < pr; r++)
            for (int w = 0; w < pv; w++)
              exp_q.push_back('{d: part_q[w], l: (r == pr-1 && w == pv-1)});
          occ++; n_done++;
          part_q.delete();
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    bit h;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, ordy, h);
  endtask

  task automatic pulse_clear();
    bit h;
    clr = 1'b1; cyc(1'b0, '0, 1'b0, h); clr = 1'b0;
  endtask

  typedef struct { int vlen; int rep; int ev; int er; bit err; } cfg_t;
  cfg_t tbl[7];

  initial begin
    bit h;
    int b0, l0, w, guard;
    logic [TP-1:0] cur;

    tbl[0] = '{4, 3, 4, 3, 0};
    tbl[1] = '{0, 0, 1, 1, 1};
    tbl[2] = '{12, 2, 9, 2, 1};
    tbl[3] = '{9, 5, 9, 5, 0};
    tbl[4] = '{1, 1, 1, 1, 0};
    tbl[5] = '{10, 1, 9, 1, 1};
    tbl[6] = '{2, 0, 2, 1, 1};

    rst = 1; en = 1; clr = 0; vlen_in = 4; rep_in = 3;
    feat_i_valid = 0; feat_i_data = '0; feat_o_ready = 0; feat_i_strb = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_flush();
    #1;
    chk("rst_ready", feat_i_ready, 1);
    chk("rst_valid", feat_o_valid, 0);
    chk("rst_last", last_o, 0);
    chk("rst_bank_full", bank_full_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_strb", feat_o_strb, 2'b11);

    // Single vector replayed 3 times
    vlen_in = 4; rep_in = 3;
    for (int i = 0; i < 4; i++) cyc(1'b1, TP'(16'hA0 + i), 1'b1, h);
    chk("t1_full01", bank_full_o, 2'b01);
    b0 = obs_beats; l0 = obs_last;
    idle(12, 1'b1);
    chk("t1_beats", obs_beats - b0, 12);
    chk("t1_lasts", obs_last - l0, 1);
    chk("t1_full00", bank_full_o, 2'b00);

    // Back-to-back vectors: 16 output beats must fit in 16 cycles after A completes
    vlen_in = 4; rep_in = 2;
    b0 = obs_beats; l0 = obs_last;
    for (int i = 0; i < 8; i++) cyc(1'b1, TP'(16'hB0 + i), 1'b1, h);
    idle(12, 1'b1);
    chk("t2_beats", obs_beats - b0, 16);
    chk("t2_lasts", obs_last - l0, 2);
    chk("t2_idle", feat_o_valid, 0);

    // Both banks fill with the sink stalled; C waits for A's release
    for (int i = 0; i < 8; i++) cyc(1'b1, TP'(16'hC0 + i), 1'b0, h);
    chk("t3_full11", bank_full_o, 2'b11);
    chk("t3_ready0", feat_i_ready, 0);
    w = 0; guard = 0;
    while (w < 4 && guard < 50) begin
      cyc(1'b1, TP'(16'hCC + w), 1'b1, h);
      if (h) w++;
      guard++;
    end
    chk("t3_c_loaded", w, 4);
    chk("t3_full11_c", bank_full_o, 2'b11);
    idle(20, 1'b1);
    chk("t3_drained", bank_full_o, 2'b00);

    // Clear mid-extract (rd_idx=2, rep_cnt=1); beat offered in the clear cycle is dropped
    vlen_in = 4; rep_in = 3;
    for (int i = 0; i < 4; i++) cyc(1'b1, TP'(16'hD0 + i), 1'b0, h);
    idle(6, 1'b1);
    clr = 1'b1; cyc(1'b1, TP'(16'hDEAD), 1'b1, h); clr = 1'b0;
    feat_i_valid = 1'b0;
    #1;
    chk("t5_valid", feat_o_valid, 0);
    chk("t5_full", bank_full_o, 2'b00);
    chk("t5_busy", busy_o, 0);
    vlen_in = 2; rep_in = 1;
    for (int i = 0; i < 2; i++) cyc(1'b1, TP'(16'hE0 + i), 1'b0, h);
    chk("t5_bank0", bank_full_o, 2'b01);
    idle(3, 1'b1);

    // Clamping table
    for (int i = 0; i < 7; i++) begin
      pulse_clear();
      vlen_in = VW'(tbl[i].vlen); rep_in = CNT_SIZE'(tbl[i].rep);
      for (int k = 0; k < tbl[i].ev; k++) cyc(1'b1, TP'($urandom), 1'b0, h);
      b0 = obs_beats; l0 = obs_last;
`ifdef RBE_INPUT_PINGPONG_ERR_EN
      chk("tbl_err", err_o, tbl[i].err);
`endif
      idle(tbl[i].ev * tbl[i].er + 3, 1'b1);
      chk("tbl_beats", obs_beats - b0, tbl[i].ev * tbl[i].er);
      chk("tbl_lasts", obs_last - l0, 1);
      chk("tbl_empty", feat_o_valid, 0);
`ifdef RBE_INPUT_PINGPONG_ERR_EN
      chk("tbl_err_sticky", err_o, tbl[i].err);
`endif
    end

    // Random handshakes, vlen=NREG, rep=5, 20 vectors, occasional enable drops
    pulse_clear();
    vlen_in = VW'(NREG); rep_in = 5;
    w = 0; guard = 0; cur = TP'($urandom);
    while (w < 20 * NREG && guard < 20000) begin
      en = ($urandom_range(0, 9) != 0);
      cyc(1'($urandom), cur, 1'($urandom), h);
      if (h) begin w++; cur = TP'($urandom); end
      guard++;
    end
    chk("rnd_load_done", w, 20 * NREG);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20000) begin
      en = ($urandom_range(0, 9) != 0);
      cyc(1'b0, '0, 1'($urandom), h);
      guard++;
    end
    en = 1'b1;
    chk("rnd_drained", exp_q.size(), 0);

    // Random configuration that changes every cycle, including mid-bank
    for (int i = 0; i < 800; i++) begin
      vlen_in = VW'($urandom_range(0, 12));
      rep_in  = CNT_SIZE'($urandom_range(0, 3));
      en = ($urandom_range(0, 7) != 0);
      cyc(1'($urandom), TP'($urandom), 1'($urandom), h);
    end
    en = 1'b1;
    pulse_clear();
    #1;
    chk("end_busy", busy_o, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
